// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Brief    : Bundle of controller handshake and 8-bit memory read signals
//             seen by the instruction fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 12
) ();
  // Controller side
  logic              fetchReq;
  logic              pcLoadEn;
  logic [ADDR_W-1:0] pcLoadValue;
  logic              instrValid;
  logic [3:0]        opcode;
  logic              isLong;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fault;
  // Memory side
  logic [7:0]        memData;
  logic              memReady;
  logic              memRead;
  logic [ADDR_W-1:0] memAddr;

  // The fetch unit itself
  modport slave (
    input  fetchReq, pcLoadEn, pcLoadValue, memData, memReady,
    output memRead, memAddr, instrValid, opcode, isLong, operand, pc, busy, fault
  );

  // Surrounding system: controller plus memory
  modport master (
    output fetchReq, pcLoadEn, pcLoadValue, memData, memReady,
    input  memRead, memAddr, instrValid, opcode, isLong, operand, pc, busy, fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fetches one- or two-byte instructions over an 8-bit variable
//             latency memory port; owns PC, IR and TR; raises a sticky fault
//             when memory stalls for TIMEOUT consecutive cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  wire                     clk,
  input  wire                     rst,
  instr_fetch_unit_if.slave       bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_REQ2  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        tr_q, tr_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              wait_expired;

  // Modulo-2^ADDR_W increment; also wraps between the two bytes of a long instruction.
  assign pc_inc       = pc_q + ADDR_W'(1);
  // Last allowed stall cycle: a further low memReady now ends in FAULT.
  assign wait_expired = (wait_q == CNT_W'(TIMEOUT - 1));

  // State and datapath registers; reset wipes any partially fetched instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      tr_q    <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: sequencing of byte reads, PC loads and the stall watchdog.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tr_d    = tr_q;
    wait_d  = wait_q;
    fault_d = fault_q;

    unique case (state_q)
      S_IDLE: begin
        // A same-cycle load is visible to the fetch that starts next cycle.
        if (bus.pcLoadEn) pc_d = bus.pcLoadValue;
        if (bus.fetchReq) state_d = S_REQ1;
      end

      S_REQ1: begin
        if (bus.memReady) begin
          ir_d    = bus.memData;
          pc_d    = pc_inc;
          wait_d  = '0;
          state_d = bus.memData[7] ? S_REQ2 : S_DONE;
        end else if (wait_expired) begin
          wait_d  = '0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
        end
      end

      S_REQ2: begin
        if (bus.memReady) begin
          tr_d    = bus.memData;
          pc_d    = pc_inc;
          wait_d  = '0;
          state_d = S_DONE;
        end else if (wait_expired) begin
          wait_d  = '0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Branch target may be loaded while the decoded instruction is presented.
        if (bus.pcLoadEn) pc_d = bus.pcLoadValue;
        state_d = S_IDLE;
      end

      S_FAULT: begin
        // Only a fresh PC from the controller clears a hung-memory condition.
        if (bus.pcLoadEn) begin
          pc_d    = bus.pcLoadValue;
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and held registers only.
  always_comb begin
    bus.memRead    = 1'b0;
    bus.memAddr    = '0;
    bus.instrValid = 1'b0;
    bus.busy       = 1'b0;
    if (state_q == S_REQ1 || state_q == S_REQ2) begin
      bus.memRead = 1'b1;
      bus.memAddr = pc_q;
      bus.busy    = 1'b1;
    end
    if (state_q == S_DONE) begin
      bus.instrValid = 1'b1;
      bus.busy       = 1'b1;
    end
  end

  assign bus.opcode  = ir_q[7:4];
  assign bus.isLong  = ir_q[7];
  // Short instructions ignore TR, which may be stale from an earlier fetch.
  assign bus.operand = ir_q[7] ? ADDR_W'({ir_q[3:0], tr_q}) : ADDR_W'(ir_q[3:0]);
  assign bus.pc      = pc_q;
  assign bus.fault   = fault_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that sits directly upstream of the multi-cycle controller. It owns the program counter, the instruction register (IR) and the temporary register (TR), and reads one- or two-byte instructions from an 8-bit memory port that has a variable-latency `memReady` handshake. It hands the controller a decoded opcode and operand with a one-cycle `instrValid` strobe. A wait-state watchdog flags a hung memory.

## Interface
- `ADDR_W`, 12: program counter and memory address width.
- `RESET_PC`, 0: program counter value after reset.
- `TIMEOUT`, 15: maximum number of consecutive cycles without `memReady` in a request state before a fault is raised.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetchReq` in 1: controller requests the next instruction; sampled only in IDLE.
- `pcLoadEn` in 1: load `pcLoadValue` into PC (branch or jump); honoured only in IDLE, DONE or FAULT.
- `pcLoadValue` in ADDR_W: new PC value.
- `memData` in 8: read data; valid when `memReady`=1.
- `memReady` in 1: memory completes the current read this cycle.
- `memRead` out 1: read strobe; high in REQ1 and REQ2.
- `memAddr` out ADDR_W: combinational copy of PC in REQ1 and REQ2; 0 in all other states.
- `instrValid` out 1: one-cycle strobe in DONE.
- `opcode` out 4: IR[7:4].
- `isLong` out 1: IR[7].
- `operand` out ADDR_W: if `isLong`, {IR[3:0], TR}; otherwise IR[3:0] zero-extended.
- `pc` out ADDR_W: current PC.
- `busy` out 1: high in REQ1, REQ2 and DONE.
- `fault` out 1: sticky memory-timeout flag.

## Operation
- States: IDLE, REQ1, REQ2, DONE, FAULT.
- Reset values: state=IDLE, PC=RESET_PC, IR=0, TR=0, wait counter=0, `fault`=0.
  - All outputs are therefore 0, except `pc`=RESET_PC.
- IDLE:
  - If `pcLoadEn`=1, PC←`pcLoadValue`.
  - If `fetchReq`=1, go to REQ1.
  - When both are high in the same cycle, the load happens and the fetch uses the new PC.
- REQ1:
  - `memRead`=1, `memAddr`=PC.
  - On `memReady`: IR←`memData`, PC←PC+1, wait counter←0.
  - Next state is REQ2 if `memData[7]`=1, otherwise DONE.
- REQ2:
  - `memRead`=1, `memAddr`=PC.
  - On `memReady`: TR←`memData`, PC←PC+1, wait counter←0, go to DONE.
- Wait counter:
  - In REQ1 and REQ2, each cycle with `memReady`=0 increments the counter.
  - When the counter reaches TIMEOUT with `memReady` still low, go to FAULT and set `fault`=1.
  - PC, IR and TR keep their values.
- DONE:
  - `instrValid`=1 and outputs are stable; unconditionally return to IDLE.
  - `pcLoadEn` is applied here.
  - `fetchReq` in DONE is ignored; the controller re-requests in IDLE.
- FAULT:
  - `memRead`=0.
  - Exit only on `pcLoadEn`=1: PC←`pcLoadValue`, `fault`←0, go to IDLE.
  - `fetchReq` is ignored.
- `fetchReq` in REQ1 or REQ2 is ignored; `pcLoadEn` in REQ1 or REQ2 is ignored (no queuing).
- PC arithmetic is modulo 2^ADDR_W, so the all-ones address wraps to 0, including between the two bytes of a long instruction.
- IR and TR hold their values until overwritten.
  - `opcode`, `isLong` and `operand` are valid from DONE until the next REQ1 completes.
  - For short instructions TR is stale and is not part of `operand`.

## Timing
- Zero-wait memory (`memReady` high in the same cycle as `memRead`):
  - Short instruction: `fetchReq` in cycle 0 (IDLE), REQ1 in cycle 1, `instrValid` in cycle 2.
  - Long instruction: `instrValid` in cycle 3.
- Each wait cycle adds one cycle of latency per byte.
- `memAddr` and `memRead` are combinational from state and PC. `memData` is sampled on the edge where `memReady`=1.
- FAULT is entered on the edge ending the TIMEOUT-th consecutive low-`memReady` cycle of one request. `fault` goes high the cycle after that edge.
- Asynchronous `rst` mid-fetch returns immediately to IDLE with reset values. No partial IR update survives.

## Test plan
- Short fetch, zero wait: PC=0x010, memory[0x010]=0x35, pulse `fetchReq` → `memAddr`=0x010 in cycle 1; `instrValid` in cycle 2 with `opcode`=3, `isLong`=0, `operand`=0x005; PC=0x011.
- Long fetch, 2 wait states per byte: memory[0x020]=0xA7, memory[0x021]=0x4C → `instrValid` in cycle 7; `opcode`=0xA, `isLong`=1, `operand`=0x74C; PC=0x022.
- Wrap-around: PC=0xFFF, byte 0x80 followed by 0x12 at address 0x000 → second read at `memAddr`=0x000; `operand`=0x012; PC=0x001.
- Simultaneous load and request in IDLE: `pcLoadEn`=1, `pcLoadValue`=0x300, `fetchReq`=1 → REQ1 `memAddr`=0x300. `pcLoadEn`=1 during REQ1 → PC unaffected.
- Timeout: `memReady` held 0 for 15 cycles in REQ1 → `fault`=1, `memRead`=0. `fetchReq` ignored. `pcLoadEn` with 0x040 → IDLE, `fault`=0, PC=0x040.
- Reset mid-fetch: assert `rst` during REQ2 → state IDLE, PC=RESET_PC, IR=TR=0, `memRead`=0 and `instrValid`=0 immediately.
